parity_frame_checker: RTL
=========================

Name: parity_frame_checker

Overview:
- Multi-lane serial parity checker; successor to the single-bit running-parity FSM.
- CH lanes share one framing stream. Each frame is FRAME_LEN data bits followed by one parity bit.
- Per lane, the block checks even or odd parity, flags errors at end of frame, and counts bad frames.
- Sits behind serial receivers; feeds the error/status logic.

Parameters:
CH, 2, number of independent serial lanes (>=1)
FRAME_LEN, 8, data bits per frame excluding parity bit (>=1)
ERR_CNT_W, 8, width of saturating bad-frame counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  bit slot valid on all lanes this cycle
sof  input  1  start of frame; qualified by in_valid; marks first data bit
odd_mode  input  1  1 = odd parity expected, 0 = even; sampled on accepted sof
in_bit  input  CH  serial bit per lane
busy  output  1  frame in progress (state != IDLE)
par_run  output  CH  running XOR of accepted data bits of current frame, per lane
frame_done  output  1  one-cycle pulse after parity bit accepted
parity_err  output  CH  per-lane error result of last completed frame
err_count  output  ERR_CNT_W  frames with >=1 lane error, saturating

Behaviour:
- Reset (async, rst_n=0): state=IDLE, bit_cnt=0, mode latch=0, busy=0, par_run=0, frame_done=0, parity_err=0, err_count=0. Any partial frame is discarded.
- An accepted beat is in_valid=1 on a rising clk edge. When in_valid=0 nothing changes (gaps allowed anywhere), except that frame_done drops.
- FSM states: IDLE, DATA, CHECK.
- IDLE:
  - Accepted beat with sof=1: par_run<=in_bit, bit_cnt<=1, mode latch<=odd_mode.
  - Next state is CHECK if FRAME_LEN==1, else DATA.
  - Accepted beat with sof=0 is ignored.
- DATA: each accepted beat does par_run<=par_run^in_bit and bit_cnt<=bit_cnt+1. When bit_cnt+1==FRAME_LEN, go to CHECK.
- CHECK: the accepted beat is the parity bit. Per lane i, the error is par_run[i]^in_bit[i]^mode.
  - Even mode: the total count of ones, parity bit included, must be even.
  - Odd mode: that total must be odd.
  - On the next edge:
    - parity_err<=error vector
    - frame_done<=1
    - par_run<=0
    - bit_cnt<=0
    - state<=IDLE
    - err_count increments by 1 if any error bit is set. It holds at all-ones.
- Latency: frame_done and parity_err are valid in the cycle after the parity-bit edge. parity_err holds until the next frame_done.
- frame_done is exactly one cycle wide.
- busy=1 in DATA and CHECK.
- A new sof is accepted in IDLE in the cycle frame_done is high, so back-to-back frames need no idle slot.
- odd_mode changes mid-frame have no effect; only the latched value is used.
- bit_cnt width is clog2(FRAME_LEN+1).
- All outputs are registered.
- Mid-frame sof (DATA or CHECK) is governed by the optional feature below.

Optional Feature:
Macro: PARITY_RESYNC_EN
- Defined: an accepted sof in DATA or CHECK aborts the current frame with no frame_done and no error count. That beat is treated as a fresh first data bit:
  - par_run<=in_bit, bit_cnt<=1
  - mode latch re-sampled
  - next state CHECK if FRAME_LEN==1, else DATA
- Not defined: sof is ignored outside IDLE. The beat is processed as an ordinary data or parity bit.

Test Plan:
1. Reset, CH=2, FRAME_LEN=4, even mode.
   - Stimulus: lanes {1,0,1,1} and {1,1,0,0}, parity bits 1 and 0, consecutive beats.
   - Response: frame_done pulses 1 cycle after the 5th beat; parity_err=2'b00; err_count=0; par_run cleared to 0.
2. Same frame with lane0 parity bit flipped to 0.
   - Response: parity_err=2'b01; err_count=1.
   - The following clean frame gives parity_err=2'b00 and err_count stays 1.
3. odd_mode=1 at sof, toggled to 0 mid-frame.
   - Stimulus: data {0,0,0,1}, parity 0.
   - Response: no error, because odd mode was latched.
4. in_valid gaps: 3 idle cycles inserted between each beat.
   - Response: same results as scenario 1; busy stays high through the gaps.
5. Assert rst_n=0 asynchronously after 2 data beats.
   - Response: all outputs go to 0 immediately.
   - The next sof starts a clean frame that completes correctly.
6. sof re-asserted on the 3rd beat of a frame.
   - With PARITY_RESYNC_EN: no frame_done until 4 data bits plus parity have been accepted counting from the new sof.
   - Without it: frame_done fires after 5 beats counted from the original sof.
   - Bench also covers err_count saturation at 255 using ERR_CNT_W=8.

Source files
------------

// File: rtl/parity_frame_checker_if.sv
// rtl/parity_frame_checker_if.sv - beat input and check result bundle for parity_frame_checker
interface parity_frame_checker_if #(
  parameter int CH        = 2,
  parameter int ERR_CNT_W = 8
);
  logic                 in_valid;
  logic                 sof;
  logic                 odd_mode;
  logic [CH-1:0]        in_bit;
  logic                 busy;
  logic [CH-1:0]        par_run;
  logic                 frame_done;
  logic [CH-1:0]        parity_err;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output in_valid, sof, odd_mode, in_bit,
    input  busy, par_run, frame_done, parity_err, err_count
  );

  modport slave (
    input  in_valid, sof, odd_mode, in_bit,
    output busy, par_run, frame_done, parity_err, err_count
  );
endinterface

// File: rtl/parity_frame_checker.sv
// rtl/parity_frame_checker.sv - multi-lane serial parity frame checker; PARITY_RESYNC_EN lets a mid-frame sof restart the frame
module parity_frame_checker #(
  parameter int CH        = 2,
  parameter int FRAME_LEN = 8,
  parameter int ERR_CNT_W = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  parity_frame_checker_if.slave bus
);
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(FRAME_LEN - 1);

`ifdef PARITY_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2
  } state_t;

  // A one-bit frame goes straight from its sof beat to the parity beat
  localparam state_t FIRST_NEXT = state_t'((FRAME_LEN == 1) ? CHECK : DATA);

  state_t               state;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 mode_q;
  logic                 busy_q;
  logic                 frame_done_q;
  logic [CH-1:0]        par_run_q;
  logic [CH-1:0]        parity_err_q;
  logic [ERR_CNT_W-1:0] err_count_q;
  logic                 start;
  logic [CH-1:0]        err_vec;

  // sof opens a frame in IDLE, or anywhere when resync is built in
  assign start   = bus.sof && ((state == IDLE) || RESYNC);
  // Lane error: data parity, parity bit and the latched mode do not cancel out
  assign err_vec = par_run_q ^ bus.in_bit ^ {CH{mode_q}};

  // Frame FSM with registered status; idle slots only retire frame_done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      mode_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      par_run_q    <= '0;
      parity_err_q <= '0;
      err_count_q  <= '0;
    end else begin
      frame_done_q <= 1'b0;
      if (bus.in_valid) begin
        if (start) begin
          par_run_q <= bus.in_bit;
          bit_cnt   <= CNT_W'(1);
          mode_q    <= bus.odd_mode;
          state     <= FIRST_NEXT;
          busy_q    <= 1'b1;
        end else begin
          case (state)
            IDLE: ;
            DATA: begin
              par_run_q <= par_run_q ^ bus.in_bit;
              bit_cnt   <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_DATA) state <= CHECK;
            end
            CHECK: begin
              parity_err_q <= err_vec;
              frame_done_q <= 1'b1;
              par_run_q    <= '0;
              bit_cnt      <= '0;
              state        <= IDLE;
              busy_q       <= 1'b0;
              if ((|err_vec) && (err_count_q != '1)) err_count_q <= err_count_q + 1'b1;
            end
            default: begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.par_run    = par_run_q;
  assign bus.frame_done = frame_done_q;
  assign bus.parity_err = parity_err_q;
  assign bus.err_count  = err_count_q;
endmodule
